// File: rtl/meter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : meter_pkg
// Brief    : Shared types, widths and helpers for the microphone peak meter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package meter_pkg;

  // Window state: collecting samples, or the single publish cycle
  typedef enum logic [0:0] {
    ACCUM   = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  localparam int MIC_MID = 2048;
  localparam int MAG_W   = 11;
  localparam int LEVEL_W = 5;
  localparam int BAR_W   = 16;

  // Thermometer code: bits [lvl-1:0] set, saturating at a full bar
  function automatic logic [BAR_W-1:0] level_to_bar(input logic [LEVEL_W-1:0] lvl);
    logic [BAR_W-1:0] bar;
    bar = '0;
    for (int i = 0; i < BAR_W; i++) begin
      if (i < int'(lvl)) bar[i] = 1'b1;
    end
    return bar;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mic_peak_meter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mic_peak_meter_if
// Brief    : Sample input and level output bundle of the peak meter.
//            master = sample source / display side, slave = meter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface mic_peak_meter_if
  import meter_pkg::*;
();
  logic               sample_valid;
  logic [11:0]        mic_in;
  logic [MAG_W-1:0]   peak;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] hold_level;
  logic [BAR_W-1:0]   led_bar;
  logic               level_valid;

  modport master (
    output sample_valid, mic_in,
    input  peak, level, hold_level, led_bar, level_valid
  );

  modport slave (
    input  sample_valid, mic_in,
    output peak, level, hold_level, led_bar, level_valid
  );
endinterface
`default_nettype wire

// File: rtl/mic_level_quantizer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mic_level_quantizer
// Brief    : Combinational peak magnitude -> 0..16 level and thermometer bar.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module mic_level_quantizer
  import meter_pkg::*;
#(
  parameter int NOISE_FLOOR = 64,
  parameter int LEVEL_SHIFT = 7
) (
  input  wire logic [MAG_W-1:0]   i_peak,
  output logic      [LEVEL_W-1:0] o_level,
  output logic      [BAR_W-1:0]   o_bar
);

  localparam logic [MAG_W-1:0] c_floor     = MAG_W'(NOISE_FLOOR);
  // Step count at which the level saturates (15 steps + 1 = 16)
  localparam logic [MAG_W-1:0] c_sat_steps = MAG_W'(15);

  logic [MAG_W-1:0]   w_above;
  logic [MAG_W-1:0]   w_steps;
  logic [LEVEL_W-1:0] w_level;

  // Quantise: below the floor is silence, above it one level per 2^LEVEL_SHIFT
  always_comb begin
    w_above = i_peak - c_floor;
    w_steps = w_above >> LEVEL_SHIFT;
    w_level = '0;
    if (i_peak < c_floor) begin
      w_level = '0;
    end else if (w_steps >= c_sat_steps) begin
      w_level = LEVEL_W'(16);
    end else begin
      w_level = LEVEL_W'(w_steps) + LEVEL_W'(1);
    end
  end

  assign o_level = w_level;
  assign o_bar   = level_to_bar(w_level);

endmodule
`default_nettype wire

// File: rtl/mic_peak_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mic_peak_meter
// Brief    : Windowed peak-deviation meter for 12-bit mic samples. Publishes
//            peak, level, hold level and LED bar once per window.
//            Optional macro METER_HOLD_EN enables the decaying peak-hold
//            level and the floating peak dot on the LED bar.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module mic_peak_meter
  import meter_pkg::*;
#(
  parameter int WINDOW_SAMPLES = 4000,
  parameter int NOISE_FLOOR    = 64,
  parameter int LEVEL_SHIFT    = 7,
  parameter int HOLD_WINDOWS   = 4
) (
  input wire logic        basys_clock,
  input wire logic        reset,
  mic_peak_meter_if.slave bus
);

  if ((WINDOW_SAMPLES < 1) || (WINDOW_SAMPLES > 65535) || (HOLD_WINDOWS < 1)) begin : g_bad_param
    $error("mic_peak_meter: parameter out of range");
  end

  localparam logic [16:0] c_window = 17'(WINDOW_SAMPLES);

  state_t             r_state;
  logic [15:0]        r_count;
  logic [MAG_W-1:0]   r_win_max;
  logic [MAG_W-1:0]   r_peak;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] r_hold_level;
  logic [BAR_W-1:0]   r_led_bar;
  logic               r_level_valid;

  logic [11:0]        w_diff;
  logic [MAG_W-1:0]   w_mag;
  logic [MAG_W-1:0]   w_win_max_upd;
  logic [16:0]        w_count_inc;
  logic [LEVEL_W-1:0] w_q_level;
  logic [BAR_W-1:0]   w_q_bar;
  logic [LEVEL_W-1:0] w_hold_next;
  logic [BAR_W-1:0]   w_bar_next;

  // |mic_in - mid|, with the single out-of-range case (mic_in = 0) clamped
  always_comb begin
    w_diff = 12'(MIC_MID) - bus.mic_in;
    w_mag  = '0;
    if (bus.mic_in[11]) begin
      w_mag = bus.mic_in[MAG_W-1:0];
    end else if (w_diff[11]) begin
      w_mag = {MAG_W{1'b1}};
    end else begin
      w_mag = w_diff[MAG_W-1:0];
    end
  end

  assign w_win_max_upd = (w_mag > r_win_max) ? w_mag : r_win_max;
  assign w_count_inc   = {1'b0, r_count} + 17'd1;

  mic_level_quantizer #(
    .NOISE_FLOOR (NOISE_FLOOR),
    .LEVEL_SHIFT (LEVEL_SHIFT)
  ) u_quant (
    .i_peak  (r_win_max),
    .o_level (w_q_level),
    .o_bar   (w_q_bar)
  );

`ifdef METER_HOLD_EN
  logic [15:0]        r_hold_cnt;
  logic [15:0]        w_hold_cnt_next;
  logic [LEVEL_W-1:0] w_hold_dec;

  // Hold tracks new highs; after HOLD_WINDOWS stale publishes it steps down
  // once per HOLD_WINDOWS publishes, never undercutting the live level
  always_comb begin
    w_hold_dec      = r_hold_level - LEVEL_W'(1);
    w_hold_next     = r_hold_level;
    w_hold_cnt_next = r_hold_cnt;
    if (w_q_level >= r_hold_level) begin
      w_hold_next     = w_q_level;
      w_hold_cnt_next = '0;
    end else if (r_hold_cnt >= 16'(HOLD_WINDOWS)) begin
      w_hold_next     = (w_hold_dec > w_q_level) ? w_hold_dec : w_q_level;
      w_hold_cnt_next = 16'd1;
    end else begin
      w_hold_cnt_next = r_hold_cnt + 16'd1;
    end
    w_bar_next = w_q_bar;
    if (w_hold_next != '0) begin
      w_bar_next = w_q_bar | (BAR_W'(1) << (w_hold_next - LEVEL_W'(1)));
    end
  end

  // Stale-publish counter advances only on publish cycles
  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (r_state == PUBLISH) begin
      r_hold_cnt <= w_hold_cnt_next;
    end
  end
`else
  assign w_hold_next = w_q_level;
  assign w_bar_next  = w_q_bar;
`endif

  // Window FSM: accumulate max/count, then one publish cycle that registers
  // the outputs and lets a coincident sample open the next window
  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      r_state       <= ACCUM;
      r_count       <= '0;
      r_win_max     <= '0;
      r_peak        <= '0;
      r_level       <= '0;
      r_hold_level  <= '0;
      r_led_bar     <= '0;
      r_level_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_level_valid <= 1'b0;
          if (bus.sample_valid) begin
            r_win_max <= w_win_max_upd;
            r_count   <= w_count_inc[15:0];
            if (w_count_inc >= c_window) r_state <= PUBLISH;
          end else if ({1'b0, r_count} >= c_window) begin
            // Only reachable with a one-sample window filled during PUBLISH
            r_state <= PUBLISH;
          end
        end
        PUBLISH: begin
          r_peak        <= r_win_max;
          r_level       <= w_q_level;
          r_hold_level  <= w_hold_next;
          r_led_bar     <= w_bar_next;
          r_level_valid <= 1'b1;
          r_state       <= ACCUM;
          if (bus.sample_valid) begin
            r_win_max <= w_mag;
            r_count   <= 16'd1;
          end else begin
            r_win_max <= '0;
            r_count   <= '0;
          end
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

  assign bus.peak        = r_peak;
  assign bus.level       = r_level;
  assign bus.hold_level  = r_hold_level;
  assign bus.led_bar     = r_led_bar;
  assign bus.level_valid = r_level_valid;

endmodule
`default_nettype wire

// File: doc/mic_peak_meter.md
# mic_peak_meter

Audio level meter sitting directly downstream of the microphone capture path and upstream of the LED bar and seven-segment display. It consumes the 12-bit unsigned samples delivered at the 20 kHz sample strobe and tracks the peak deviation from mid-scale over a fixed window of samples. At the end of each window it publishes the peak magnitude, a quantised 0–16 level, and a 16-bit LED bar pattern. A one-cycle pulse marks each update.

## Interface
- WINDOW_SAMPLES, 4000, samples per measurement window (0.2 s at 20 kHz); legal range 1..65535
- NOISE_FLOOR, 64, magnitudes below this quantise to level 0
- LEVEL_SHIFT, 7, right-shift applied above the floor when quantising
- HOLD_WINDOWS, 4, windows between one-step decays of the hold level (hold feature only)
- basys_clock  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high
- sample_valid  in  1  one-cycle strobe; mic_in is valid in that cycle
- mic_in  in  12  unsigned mic sample, mid-scale 2048
- peak  out  11  peak magnitude of the last completed window
- level  out  5  quantised level 0..16
- hold_level  out  5  held peak level
- led_bar  out  16  thermometer bar for the LEDs
- level_valid  out  1  one-cycle pulse on each publish

## Operation
- Magnitude: mag = |mic_in − 2048|. mic_in = 0 gives 2048, which is clamped to 2047. Result is 11 bits unsigned.
- States:
  - ACCUM: each sample_valid updates win_max = max(win_max, mag) and increments count. When the accepted sample makes count reach WINDOW_SAMPLES, go to PUBLISH.
  - PUBLISH: lasts exactly one cycle. Registers peak = win_max and the derived level, hold_level and led_bar. Asserts level_valid. Returns to ACCUM.
- Window reset on PUBLISH: count resets to 0 and win_max to 0, unless sample_valid is high in the PUBLISH cycle. In that case the sample opens the new window: win_max = its mag, count = 1. Samples are never dropped.
- Level: 0 if peak < NOISE_FLOOR. Otherwise min(16, ((peak − NOISE_FLOOR) >> LEVEL_SHIFT) + 1).
- led_bar: bits [level−1:0] set. Level 0 gives 0x0000; level 16 gives 0xFFFF.
- sample_valid is ignored while reset is asserted.
- reset mid-window discards the partial window.

## Timing
- Reset values: every output is 0, state is ACCUM, count = 0, win_max = 0.
- Reset is asynchronous, active-high, and asserts immediately. Release is sampled on basys_clock.
- Publish latency: the final sample of a window is accepted at edge t. The state is PUBLISH from t to t+1. Outputs change and level_valid is high for exactly one cycle, starting at edge t+1.
- peak, level, hold_level and led_bar hold their values between publishes.
- level_valid never asserts on two consecutive cycles.
- WINDOW_SAMPLES = 1: every sample produces a publish. A sample arriving in the PUBLISH cycle produces the next publish one window later.
- count is 16 bits and never wraps, because it resets at WINDOW_SAMPLES.

## Configuration
- METER_HOLD_EN defined:
  - On each publish, hold_level = max(level, hold_level), unless HOLD_WINDOWS consecutive publishes have passed without level ≥ hold_level. In that case hold_level is decremented by 1, but never below the current level.
  - led_bar additionally sets bit hold_level−1 when hold_level > 0, giving a floating peak dot.
- METER_HOLD_EN undefined: hold_level equals level, the decay counter is not built, and led_bar is the plain thermometer.

## Structure
- Shared package meter_pkg contains:
  - the state typedef (ACCUM, PUBLISH)
  - MIC_MID = 2048
  - MAG_W = 11, LEVEL_W = 5, BAR_W = 16
  - the level-to-thermometer function
- One sub-module, mic_level_quantizer: combinational peak → level and led_bar, with NOISE_FLOOR and LEVEL_SHIFT as parameters. It is instantiated once. Its outputs are registered in PUBLISH.

## Test plan
Bench uses WINDOW_SAMPLES = 4 and default values for all other parameters.
- Reset, including assertion mid-window after 2 samples → all outputs 0. The next publish covers only samples that arrive after reset is released.
- Samples 2048 ×4 → peak 0, level 0, led_bar 0x0000, one level_valid pulse at edge t+1 after the 4th sample.
- Samples 2048, 3000, 1000, 2100 → peak 1048, level 8, led_bar 0x00FF.
- Sample 0 followed by 3× 2048 → peak 2047 (clamped), level 16, led_bar 0xFFFF. Also sample 2100 ×4 → peak 52, level 0.
- Back-to-back strobes, with sample_valid high in the PUBLISH cycle carrying 4095 → that sample counts toward the next window, whose peak is 2047. Total publishes equal samples / 4 exactly.
- METER_HOLD_EN defined: one window at level 16, then windows at level 2 → hold_level stays at 16 for the first 4 low windows, then decrements 16→15→…→2. led_bar = 0x0003 | (1 << (hold_level−1)).
